// File: rtl/idct_pkg.sv
// Shared types and helpers for the IDCT frame arbiter.
// Holds the FSM encoding, frame-length limits and the legal-length check.
package idct_pkg;

    localparam int unsigned FFTPTS_MAX = 2048;
    localparam int unsigned FFTPTS_W   = 12;

    localparam logic [FFTPTS_W-1:0] FFTPTS_RST = FFTPTS_W'(FFTPTS_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } arb_state_e;

    // Only power-of-two lengths from 16 to 2048 are accepted by the back-end.
    function automatic logic fftpts_legal(input logic [FFTPTS_W-1:0] pts);
        logic ok;
        ok = 1'b0;
        case (pts)
            12'd16, 12'd32, 12'd64, 12'd128,
            12'd256, 12'd512, 12'd1024, 12'd2048: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/idct_tag_fifo.sv
// One-bit owner-tag FIFO for frames in flight inside the back-end.
// Simultaneous push and pop are both honoured.
module idct_tag_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n_sync,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_ONE;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/idct_frame_arb.sv
// Round-robin frame arbiter sharing one IDCT back-end between two requesters.
// Output frames are tagged with the owning channel from the tag FIFO.
module idct_frame_arb
    import idct_pkg::*;
#(
    parameter int unsigned wDataInOut = 16,
    parameter int unsigned TAG_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n_sync,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic                  s0_sop,
    input  logic                  s0_eop,
    input  logic [wDataInOut-1:0] s0_real,
    input  logic [wDataInOut-1:0] s0_imag,
    input  logic [11:0]           s0_fftpts,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic                  s1_sop,
    input  logic                  s1_eop,
    input  logic [wDataInOut-1:0] s1_real,
    input  logic [wDataInOut-1:0] s1_imag,
    input  logic [11:0]           s1_fftpts,
    output logic                  m_valid,
    output logic                  m_sop,
    output logic                  m_eop,
    input  logic                  m_ready,
    output logic [wDataInOut-1:0] m_real,
    output logic [wDataInOut-1:0] m_imag,
    output logic [11:0]           m_fftpts,
    input  logic                  r_valid,
    input  logic                  r_sop,
    input  logic                  r_eop,
    input  logic [wDataInOut-1:0] r_real,
    input  logic [wDataInOut-1:0] r_imag,
    output logic                  r_ready,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [wDataInOut-1:0] out_real,
    output logic [wDataInOut-1:0] out_imag,
    output logic                  out_ch,
    input  logic                  out_ready,
    output logic                  err_len,
    output logic                  err_pts
);

    arb_state_e  state_q, state_d;
    logic        ch_q, ch_d;
    logic        last_q, last_d;
    logic [11:0] pts_q, pts_d;
    logic [11:0] cnt_q, cnt_d;
    logic        err_len_q, err_len_d;
    logic        err_pts_q, err_pts_d;

    logic                  g_valid;
    logic                  g_sop;
    logic                  g_eop;
    logic [wDataInOut-1:0] g_real;
    logic [wDataInOut-1:0] g_imag;

    logic        req0;
    logic        req1;
    logic        grant_ch;
    logic [11:0] grant_pts;
    logic        pts_last;
    logic        eop_int;
    logic        m_xfer;

    logic tag_push;
    logic tag_pop;
    logic tag_head;
    logic tag_full;
    logic tag_empty;

    assign g_valid = ch_q ? s1_valid : s0_valid;
    assign g_sop   = ch_q ? s1_sop   : s0_sop;
    assign g_eop   = ch_q ? s1_eop   : s0_eop;
    assign g_real  = ch_q ? s1_real  : s0_real;
    assign g_imag  = ch_q ? s1_imag  : s0_imag;

    assign req0 = s0_valid & s0_sop;
    assign req1 = s1_valid & s1_sop;

    // On a tie the channel that did not win last time gets the frame.
    assign grant_ch  = (req0 & req1) ? ~last_q : req1;
    assign grant_pts = grant_ch ? s1_fftpts : s0_fftpts;

    assign pts_last = (cnt_q == (pts_q - 12'd1));
    assign eop_int  = g_eop | pts_last;
    assign m_xfer   = m_valid & m_ready;

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        last_d    = last_q;
        pts_d     = pts_q;
        cnt_d     = cnt_q;
        err_len_d = 1'b0;
        err_pts_d = 1'b0;
        s0_ready  = 1'b0;
        s1_ready  = 1'b0;
        m_valid   = 1'b0;
        m_sop     = 1'b0;
        m_eop     = 1'b0;
        m_real    = '0;
        m_imag    = '0;
        tag_push  = 1'b0;
        unique case (state_q)
            IDLE: begin
                s0_ready = s0_valid & ~s0_sop;
                s1_ready = s1_valid & ~s1_sop;
                cnt_d    = '0;
                if ((req0 | req1) & ~tag_full) begin
                    ch_d      = grant_ch;
                    pts_d     = grant_pts;
                    state_d   = fftpts_legal(grant_pts) ? PASS : DROP;
                    err_pts_d = ~fftpts_legal(grant_pts);
                end
            end
            PASS: begin
                m_valid = g_valid;
                m_sop   = g_valid & g_sop & (cnt_q == 12'd0);
                m_eop   = g_valid & eop_int;
                m_real  = g_real;
                m_imag  = g_imag;
                if (ch_q) s1_ready = m_ready;
                else      s0_ready = m_ready;
                if (m_xfer) begin
                    cnt_d     = cnt_q + 12'd1;
                    tag_push  = (cnt_q == 12'd0);
                    err_len_d = g_eop ^ pts_last;
                    if (eop_int) begin
                        state_d = IDLE;
                        last_d  = ch_q;
                    end
                end
            end
            DROP: begin
                if (ch_q) s1_ready = 1'b1;
                else      s0_ready = 1'b1;
                if (g_valid & g_eop) begin
                    state_d = IDLE;
                    last_d  = ch_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            state_q   <= IDLE;
            ch_q      <= 1'b0;
            last_q    <= 1'b1;
            pts_q     <= FFTPTS_RST;
            cnt_q     <= '0;
            err_len_q <= 1'b0;
            err_pts_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            last_q    <= last_d;
            pts_q     <= pts_d;
            cnt_q     <= cnt_d;
            err_len_q <= err_len_d;
            err_pts_q <= err_pts_d;
        end
    end

    assign m_fftpts = pts_q;
    assign err_len  = err_len_q;
    assign err_pts  = err_pts_q;

    // Results are only released while an owner tag is known.
    assign out_valid = r_valid & ~tag_empty;
    assign r_ready   = out_ready & ~tag_empty;
    assign out_sop   = r_sop;
    assign out_eop   = r_eop;
    assign out_real  = r_real;
    assign out_imag  = r_imag;
    assign out_ch    = tag_head;
    assign tag_pop   = r_valid & r_ready & r_eop;

    idct_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst_n_sync (rst_n_sync),
        .push_i     (tag_push),
        .din_i      (ch_q),
        .pop_i      (tag_pop),
        .dout_o     (tag_head),
        .full_o     (tag_full),
        .empty_o    (tag_empty)
    );

endmodule

// File: tb/tb_idct_frame_arb.sv
// Scoreboard bench for idct_frame_arb with a loopback back-end model.
// Forwarded beats and owner tags are queued at stimulus time and checked at output.
module tb_idct_frame_arb;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n_sync;
    logic [1:0]   sv, sr, ssop, seop;
    logic [W-1:0] sre [2];
    logic [W-1:0] sim [2];
    logic [11:0]  spts [2];
    logic         m_valid, m_sop, m_eop, m_ready;
    logic [W-1:0] m_real, m_imag;
    logic [11:0]  m_fftpts;
    logic         r_valid, r_sop, r_eop, r_ready;
    logic [W-1:0] r_real, r_imag;
    logic         out_valid, out_sop, out_eop, out_ch, out_ready;
    logic [W-1:0] out_real, out_imag;
    logic         err_len, err_pts;

    idct_frame_arb #(.wDataInOut(W), .TAG_DEPTH(2)) dut (
        .clk(clk), .rst_n_sync(rst_n_sync),
        .s0_valid(sv[0]), .s0_ready(sr[0]), .s0_sop(ssop[0]), .s0_eop(seop[0]),
        .s0_real(sre[0]), .s0_imag(sim[0]), .s0_fftpts(spts[0]),
        .s1_valid(sv[1]), .s1_ready(sr[1]), .s1_sop(ssop[1]), .s1_eop(seop[1]),
        .s1_real(sre[1]), .s1_imag(sim[1]), .s1_fftpts(spts[1]),
        .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_ready(m_ready),
        .m_real(m_real), .m_imag(m_imag), .m_fftpts(m_fftpts),
        .r_valid(r_valid), .r_sop(r_sop), .r_eop(r_eop),
        .r_real(r_real), .r_imag(r_imag), .r_ready(r_ready),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_real(out_real), .out_imag(out_imag), .out_ch(out_ch),
        .out_ready(out_ready), .err_len(err_len), .err_pts(err_pts)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_err_len = 0;
    int n_err_pts = 0;
    int e0, p0, seen;

    logic [17:0] m_q [$];
    logic [17:0] be_q [$];
    bit          ch_q [$];
    bit          sb_on = 1'b1;
    bit          be_en = 1'b1;
    bit          r_fire = 1'b0;
    bit          cur_ch = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic exp_frame(input int ch, input int id, input int nb);
        for (int i = 0; i < nb; i++) begin
            logic [15:0] d;
            d = {ch[0], id[6:0], i[7:0]};
            m_q.push_back({i == 0, i == nb - 1, d});
        end
        ch_q.push_back(ch[0]);
    endtask

    task automatic send(input int ch, input int id, input int pts,
                        input int nb, input int eop_at);
        for (int i = 0; i < nb; i++) begin
            int t = 0;
            sv[ch]   = 1'b1;
            ssop[ch] = (i == 0);
            seop[ch] = (i == eop_at);
            sre[ch]  = {ch[0], id[6:0], i[7:0]};
            sim[ch]  = ~sre[ch];
            spts[ch] = pts[11:0];
            @(negedge clk);
            while (!sr[ch] && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (!sr[ch]) begin
                check("send_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        sv[ch]   = 1'b0;
        ssop[ch] = 1'b0;
        seop[ch] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        be_en = 1'b1;
        while ((m_q.size() + ch_q.size() + be_q.size()) != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain", m_q.size() + ch_q.size() + be_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitors: forward beats, tag ordering and error pulses.
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst_n_sync) begin
            if (err_len) n_err_len++;
            if (err_pts) n_err_pts++;
        end
        r_fire = r_valid && r_ready;
        if (sb_on && m_valid && m_ready) begin
            if (m_q.size() == 0) begin
                check("m_extra", 1, 0);
            end else begin
                e = m_q.pop_front();
                check("m_beat", {m_sop, m_eop, m_real}, e);
            end
            check("other_ready", sr[!m_real[W-1]], 0);
            be_q.push_back({m_sop, m_eop, m_real});
        end
        if (out_valid && out_ready) begin
            if (out_sop) begin
                if (ch_q.size() == 0) check("out_extra", 1, 0);
                else cur_ch = ch_q.pop_front();
            end
            check("out_ch", out_ch, cur_ch);
        end
    end

    // Back-end model: replays captured frames on the return path.
    always @(posedge clk) begin
        if (r_fire && be_q.size() > 0) be_q.delete(0);
        #1;
        if (be_en && be_q.size() > 0) begin
            r_valid = 1'b1;
            {r_sop, r_eop, r_real} = be_q[0];
        end else begin
            r_valid = 1'b0;
            r_sop   = 1'b0;
            r_eop   = 1'b0;
            r_real  = '0;
        end
        r_imag = ~r_real;
    end

    initial begin
        #500000;
        $display("FAIL watchdog n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_sync = 1'b0;
        sv = '0; ssop = '0; seop = '0;
        for (int i = 0; i < 2; i++) begin
            sre[i] = '0; sim[i] = '0; spts[i] = '0;
        end
        m_ready = 1'b1;
        out_ready = 1'b1;
        r_valid = 1'b0; r_sop = 1'b0; r_eop = 1'b0;
        r_real = '0; r_imag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_fftpts", m_fftpts, 2048);
        check("rst_s_ready", sr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_r_ready", r_ready, 0);
        check("rst_err", {err_len, err_pts}, 0);
        @(posedge clk); #1;
        rst_n_sync = 1'b1;

        // Simultaneous requests twice: grants 0,1,0,1.
        @(posedge clk); #1;
        exp_frame(0, 1, 16); exp_frame(1, 2, 16);
        exp_frame(0, 3, 16); exp_frame(1, 4, 16);
        fork
            begin send(0, 1, 16, 16, 15); send(0, 3, 16, 16, 15); end
            begin send(1, 2, 16, 16, 15); send(1, 4, 16, 16, 15); end
        join
        drain();

        // Single 16-pt frame: one-cycle grant latency.
        @(posedge clk); #1;
        e0 = n_err_len;
        exp_frame(0, 5, 16);
        fork
            send(0, 5, 16, 16, 15);
            begin
                @(negedge clk);
                check("grant_m_valid", m_valid, 0);
                check("grant_s0_ready", sr[0], 0);
                @(negedge clk);
                check("first_sop", {m_valid, m_sop}, 2'b11);
                check("m_fftpts16", m_fftpts, 16);
            end
        join
        drain();
        check("no_err_len", n_err_len - e0, 0);

        // Illegal length is dropped, then a legal frame passes.
        @(posedge clk); #1;
        p0 = n_err_pts;
        send(1, 6, 100, 8, 7);
        repeat (3) @(negedge clk);
        check("err_pts_once", n_err_pts - p0, 1);
        @(posedge clk); #1;
        exp_frame(1, 7, 16);
        send(1, 7, 16, 16, 15);
        drain();

        // Early eop, then missing eop with one excess beat.
        @(posedge clk); #1;
        e0 = n_err_len;
        exp_frame(0, 8, 21);
        send(0, 8, 32, 21, 20);
        drain();
        check("err_len_early", n_err_len - e0, 1);
        @(posedge clk); #1;
        e0 = n_err_len;
        exp_frame(0, 9, 32);
        send(0, 9, 32, 33, -1);
        drain();
        check("err_len_late", n_err_len - e0, 1);

        // Tag FIFO full stalls the third grant.
        be_en = 1'b0;
        @(posedge clk); #1;
        exp_frame(0, 10, 16); exp_frame(1, 11, 16); exp_frame(0, 12, 16);
        send(0, 10, 16, 16, 15);
        send(1, 11, 16, 16, 15);
        fork
            send(0, 12, 16, 16, 15);
            begin
                seen = 0;
                repeat (30) begin
                    @(negedge clk);
                    if (m_valid) seen++;
                end
                check("stall_m_valid", seen, 0);
                be_en = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a forwarded frame.
        @(posedge clk); #1;
        sb_on = 1'b0;
        sv[0] = 1'b1; ssop[0] = 1'b1; seop[0] = 1'b0;
        sre[0] = 16'h0abc; sim[0] = ~sre[0]; spts[0] = 12'd64;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ssop[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midpass_m_valid", m_valid, 1);
        rst_n_sync = 1'b0;
        sv[0] = 1'b0;
        @(negedge clk);
        check("mrst_m_valid", m_valid, 0);
        check("mrst_m_fftpts", m_fftpts, 2048);
        check("mrst_s_ready", sr, 0);
        check("mrst_r_ready", r_ready, 0);
        be_q.push_back({1'b1, 1'b1, 16'h0000});
        be_en = 1'b1;
        @(negedge clk);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_r_ready2", r_ready, 0);
        be_q.delete();
        rst_n_sync = 1'b1;
        @(negedge clk);
        sb_on = 1'b1;
        @(posedge clk); #1;
        exp_frame(0, 13, 16);
        send(0, 13, 16, 16, 15);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/idct_frame_arb.md
Name: idct_frame_arb

Overview:
- Frame-level arbiter that shares one IDCT back-end (IFFT core followed by the post-IFFT reorder stage) between two independent requester channels.
- Grants whole frames round-robin and forwards each frame's fftpts to the back-end.
- Validates frame length and records which channel owns each frame in flight.
- Tags the back-end's output frames with the owning channel so results return to the right requester.

Parameters:
wDataInOut, 16, real/imag sample width
TAG_DEPTH, 2, max frames in flight inside the back-end (power of 2, 2..8)

Ports:
clk  in  1  single clock
rst_n_sync  in  1  reset, synchronous to clk, active low
s0_valid / s1_valid  in  1  requester sample valid
s0_ready / s1_ready  out  1  requester accept
s0_sop, s0_eop / s1_sop, s1_eop  in  1  frame delimiters
s0_real, s0_imag / s1_real, s1_imag  in  wDataInOut  sample
s0_fftpts / s1_fftpts  in  12  frame length, sampled on sop beat
m_valid, m_sop, m_eop  out  1  to back-end
m_ready  in  1  back-end accept
m_real, m_imag  out  wDataInOut  to back-end
m_fftpts  out  12  length of current/last granted frame
r_valid, r_sop, r_eop  in  1  from back-end
r_real, r_imag  in  wDataInOut  from back-end
r_ready  out  1  to back-end
out_valid, out_sop, out_eop  out  1  result stream
out_real, out_imag  out  wDataInOut  result sample
out_ch  out  1  owning channel of current result beat
out_ready  in  1  result consumer accept
err_len  out  1  1-cycle pulse: eop position mismatch
err_pts  out  1  1-cycle pulse: illegal fftpts, frame dropped

Behaviour:
- Reset: FSM=IDLE; all outputs 0 (m_fftpts=2048); tag FIFO empty; round-robin pointer set so channel 0 wins the first tie. Reset mid-frame aborts immediately; no partial frame is completed.
- Request: chN_req = sN_valid & sN_sop.
- IDLE:
  - sN_ready = sN_valid & !sN_sop, which drains stray non-sop beats silently.
  - Arbitration runs only when the tag FIFO is not full.
  - One request: grant it. Both: grant the channel not granted last.
  - Grant is registered: the next cycle enters PASS (or DROP), latches the channel, and latches fftpts into m_fftpts.
  - Legal fftpts: 16, 32, 64, 128, 256, 512, 1024, 2048. Any other value goes to DROP and pulses err_pts.
- PASS:
  - Granted channel is combinationally connected: m_valid=sG_valid, sG_ready=m_ready, data passes through, m_sop=sG_sop on first beat.
  - Other channel's ready is 0.
  - Tag (channel) is pushed on the first transferred beat.
  - A 12-bit beat counter advances per transfer (valid & ready).
  - m_eop = sG_eop | (cnt==fftpts-1).
  - err_len pulses if sG_eop arrives with cnt!=fftpts-1, or if cnt==fftpts-1 without sG_eop.
  - On the transfer of the m_eop beat: go to IDLE and update the round-robin pointer. Excess beats of an over-long frame are then drained in IDLE.
- DROP: sG_ready=1, m_valid=0. On sG_valid & sG_eop go to IDLE. The round-robin pointer updates; no tag is pushed.
- Return path:
  - out_valid = r_valid & !fifo_empty; out_sop/eop/real/imag = r_*; out_ch = FIFO head.
  - r_ready = out_ready & !fifo_empty.
  - Pop on r_valid & r_ready & r_eop.
  - Empty FIFO: r_ready=0, so the back-end stalls.
- Simultaneous push and pop in one cycle are both honoured; occupancy is unchanged.
- Latency: request to first forwarded beat is 1 cycle. Data path is 0-cycle combinational.

Decomposition:
- Shared package idct_pkg: FFTPTS_MAX=2048, the legal fftpts list/check function, FSM state encodings (IDLE=0, PASS=1, DROP=2).
- One sub-module, idct_tag_fifo: synchronous FIFO, width 1, depth TAG_DEPTH, with full/empty flags.

Test Plan:
- Ch0 sends a 16-pt frame, m_ready=1 → m_sop on cycle 1 after sop; 16 beats; m_eop on beat 15; out_ch=0 on the back-end return frame.
- Both channels request simultaneously twice → grants in order 0, 1, 0, 1. The non-granted channel's s_ready stays 0 throughout the other's frame.
- Ch1 sends fftpts=100 with 8 beats → err_pts pulses once; 8 beats are accepted and m_valid stays 0; the next legal frame is forwarded normally.
- Ch0 sends a 32-pt frame with eop on beat 20 → m_eop on beat 20 and err_len=1. Then fftpts=32 with no eop → m_eop forced on beat 31, err_len=1, the extra beat is drained in IDLE.
- TAG_DEPTH=2, r_valid held 0, three frames queued → the third grant stalls until one r_eop pop. Then return frames carry out_ch in grant order.
- Assert rst_n_sync=0 mid-PASS → next cycle all outputs 0 and FIFO empty; a new sop is granted normally.
